// File: rtl/mod_hash_seq.sv
`default_nettype none
// ============================================================================
// Module      : mod_hash_seq
// Description : Command sequencer for a hash compression core. For every
//               512-bit message block it issues LOAD_H, HASH and SUM_STORE.
//               Each command is held until the core raises rdy. The sequencer
//               then drives CMD_IDLE until the core drops rdy again. A
//               per-command watchdog aborts the job to FAIL if the core stalls.
// Ports       : clk, rst      - single rising-edge clock, sync active-high rst
//               start, nblk   - job request and block count (0 means 1)
//               rdy           - completion level from the compression core
//               cmd           - command to the core (registered)
//               blk_idx       - block being processed (W source select)
//               h_src, h_dst  - H bank read by LOAD_H / written by SUM_STORE
//               busy, done    - job in progress / one-cycle completion pulse
//               err           - sticky timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module mod_hash_seq #(
    parameter logic [7:0]  CMD_IDLE      = 8'd0,
    parameter logic [7:0]  CMD_LOAD_H    = 8'd1,
    parameter logic [7:0]  CMD_HASH      = 8'd2,
    parameter logic [7:0]  CMD_SUM_STORE = 8'd3,
    parameter logic [15:0] TMO           = 16'd1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] nblk,
    input  logic       rdy,
    output logic [7:0] cmd,
    output logic [3:0] blk_idx,
    output logic [1:0] h_src,
    output logic [1:0] h_dst,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [3:0] C_ST_IDLE     = 4'd0;
    localparam logic [3:0] C_ST_LOAD     = 4'd1;
    localparam logic [3:0] C_ST_LOAD_REL = 4'd2;
    localparam logic [3:0] C_ST_HASH     = 4'd3;
    localparam logic [3:0] C_ST_HASH_REL = 4'd4;
    localparam logic [3:0] C_ST_SUM      = 4'd5;
    localparam logic [3:0] C_ST_SUM_REL  = 4'd6;
    localparam logic [3:0] C_ST_FIN      = 4'd7;
    localparam logic [3:0] C_ST_FAIL     = 4'd8;

    logic [3:0]  r_state;
    logic [3:0]  r_last;      // index of the final block of the job
    logic [15:0] r_wdog;

    logic [3:0]  w_next_state;
    logic [3:0]  w_next_blk;
    logic [3:0]  w_next_last;
    logic [7:0]  w_next_cmd;
    logic        w_tmo;
    logic        w_next_busy;

    // The watchdog is cleared on each state change, so r_wdog counts the
    // cycles already spent in the current state. The job aborts once TMO
    // cycles have elapsed without the expected rdy level.
    assign w_tmo = (r_wdog == (TMO - 16'd1));

    always_comb begin
        w_next_state = r_state;
        w_next_blk   = blk_idx;
        w_next_last  = r_last;
        case (r_state)
            C_ST_IDLE: begin
                if (start) begin
                    w_next_state = C_ST_LOAD;
                    w_next_blk   = 4'd0;
                    w_next_last  = (nblk == 4'd0) ? 4'd0 : (nblk - 4'd1);
                end
            end
            // rdy is level-sensitive: a level already high on entry completes.
            C_ST_LOAD: begin
                if (rdy)        w_next_state = C_ST_LOAD_REL;
                else if (w_tmo) w_next_state = C_ST_FAIL;
            end
            C_ST_LOAD_REL: begin
                if (!rdy)       w_next_state = C_ST_HASH;
                else if (w_tmo) w_next_state = C_ST_FAIL;
            end
            C_ST_HASH: begin
                if (rdy)        w_next_state = C_ST_HASH_REL;
                else if (w_tmo) w_next_state = C_ST_FAIL;
            end
            C_ST_HASH_REL: begin
                if (!rdy)       w_next_state = C_ST_SUM;
                else if (w_tmo) w_next_state = C_ST_FAIL;
            end
            C_ST_SUM: begin
                if (rdy)        w_next_state = C_ST_SUM_REL;
                else if (w_tmo) w_next_state = C_ST_FAIL;
            end
            C_ST_SUM_REL: begin
                if (!rdy) begin
                    if (blk_idx == r_last) begin
                        w_next_state = C_ST_FIN;
                    end else begin
                        w_next_state = C_ST_LOAD;
                        w_next_blk   = blk_idx + 4'd1;
                    end
                end else if (w_tmo) begin
                    w_next_state = C_ST_FAIL;
                end
            end
            C_ST_FIN:  w_next_state = C_ST_IDLE;
            C_ST_FAIL: w_next_state = C_ST_IDLE;
            default:   w_next_state = C_ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so each output
    // reflects the state the controller is in during that cycle.
    always_comb begin
        w_next_cmd = CMD_IDLE;
        case (w_next_state)
            C_ST_LOAD: w_next_cmd = CMD_LOAD_H;
            C_ST_HASH: w_next_cmd = CMD_HASH;
            C_ST_SUM:  w_next_cmd = CMD_SUM_STORE;
            default:   w_next_cmd = CMD_IDLE;
        endcase
    end

    assign w_next_busy = (w_next_state != C_ST_IDLE) &&
                         (w_next_state != C_ST_FIN)  &&
                         (w_next_state != C_ST_FAIL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_ST_IDLE;
            r_last  <= 4'd0;
            r_wdog  <= 16'd0;
            cmd     <= CMD_IDLE;
            blk_idx <= 4'd0;
            h_src   <= 2'd0;
            h_dst   <= 2'd1;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_last  <= w_next_last;
            blk_idx <= w_next_blk;
            cmd     <= w_next_cmd;
            busy    <= w_next_busy;
            done    <= (w_next_state == C_ST_FIN);

            if (w_next_state != r_state)
                r_wdog <= 16'd0;
            else if (w_next_busy)
                r_wdog <= r_wdog + 16'd1;

            if ((r_state == C_ST_IDLE) && start)
                err <= 1'b0;
            else if (w_next_state == C_ST_FAIL)
                err <= 1'b1;

            // Bank selects only move when a block starts, keeping them stable
            // for the whole LOAD/HASH/SUM sequence of that block.
            if (w_next_state == C_ST_LOAD) begin
                h_src <= (w_next_blk == 4'd0) ? 2'd0 : 2'd1;
                h_dst <= (w_next_blk == w_next_last) ? 2'd2 : 2'd1;
            end
        end
    end

endmodule
`default_nettype wire
